hex_keypad_emulator: RTL and testbench

Behavioural/synthesizable model of the 4x4 hex keypad: the matrix end of the column-scan/row-sense interface that the keypad scanner drives. Key codes queued on a valid/ready port are "pressed" one at a time with a programmable contact-bounce, hold and release-gap sequence. While a key is closed, the block returns row lines as a combinational function of the column lines driven by the scanner. Used in benches and on FPGA loopback to exercise the scanner, synchronizer and debounce path without physical keys.

---
 rtl/hex_keypad_emulator_if.sv | 28 ++
 rtl/hex_keypad_emulator.sv | 174 +++++++++++++++++
 tb/tb_hex_keypad_emulator.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_keypad_emulator_if.sv
// Key-code queue port and matrix column/row lines of the hex keypad emulator.
// The scanner/bench side uses master; the emulator uses slave.
interface hex_keypad_emulator_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]         key_code;
  logic               key_valid;
  logic               key_ready;
  logic               flush;
  logic [3:0]         col;
  logic [3:0]         row;
  logic               pressed;
  logic               busy;
  logic               key_done;
  logic [COUNT_W-1:0] fifo_count;

  modport master (
    output key_code, key_valid, flush, col,
    input  key_ready, row, pressed, busy, key_done, fifo_count
  );

  modport slave (
    input  key_code, key_valid, flush, col,
    output key_ready, row, pressed, busy, key_done, fifo_count
  );
endinterface

// File: rtl/hex_keypad_emulator.sv
// 4x4 hex keypad matrix model: queued key codes are pressed one at a time with
// bounce/hold/bounce/gap timing, and rows answer the scanner's columns directly.
module hex_keypad_emulator #(
  parameter int HOLD_CYCLES   = 64,
  parameter int BOUNCE_CYCLES = 8,
  parameter int GAP_CYCLES    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  hex_keypad_emulator_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cur_key;
  logic             r_pressed;
  logic             r_key_done;
  logic             r_busy;

  logic             w_key_ready;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_row;

  assign w_key_ready = (r_count < DEPTH_C);
  assign w_push      = bus.key_valid & w_key_ready & ~bus.flush;
  assign w_pop       = (r_state == S_IDLE) & (r_count != '0) & ~bus.flush;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // Queue storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.key_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // pressed is loaded with the value belonging to the next state/count, so it
  // is a clean register output; bounce phases alternate on the count's LSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_key  <= '0;
      r_pressed  <= 1'b0;
      r_key_done <= 1'b0;
      r_busy     <= 1'b0;
    end else if (bus.flush) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
      r_key_done <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_key_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_key <= r_mem[r_rd_ptr];
            r_cnt     <= '0;
            r_pressed <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE_IN;
          end
        end
        S_BOUNCE_IN: begin
          if (r_cnt == BOUNCE_LAST) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_pressed <= 1'b1;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_pressed <= r_cnt[0];
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
            if (BOUNCE_CYCLES == 0) begin
              r_state    <= S_GAP;
              r_key_done <= (GAP_CYCLES == 1);
            end else begin
              r_state <= S_BOUNCE_OUT;
            end
          end else begin
            r_cnt     <= w_cnt_inc;
            r_pressed <= 1'b1;
          end
        end
        S_BOUNCE_OUT: begin
          if (r_cnt == BOUNCE_LAST) begin
            r_state    <= S_GAP;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_key_done <= (GAP_CYCLES == 1);
          end else begin
            r_cnt     <= w_cnt_inc;
            r_pressed <= ~r_cnt[0];
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt      <= w_cnt_inc;
            r_key_done <= (w_cnt_inc == GAP_LAST);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // The closed key shorts its column to its row with no clock in the path.
  always_comb begin
    w_row = '0;
    for (int i = 0; i < 4; i++) begin
      w_row[i] = r_pressed & (r_cur_key[3:2] == 2'(i)) & bus.col[r_cur_key[1:0]];
    end
  end

  assign bus.row        = w_row;
  assign bus.pressed    = r_pressed;
  assign bus.busy       = r_busy;
  assign bus.key_done   = r_key_done;
  assign bus.key_ready  = w_key_ready;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Scoreboard bench for hex_keypad_emulator: a key-queue/sequence-position model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_hex_keypad_emulator;
  localparam int HOLD   = 4;
  localparam int BOUNCE = 3;
  localparam int GAP    = 2;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = 2 * BOUNCE + HOLD + GAP;

  logic clock = 1'b0;
  logic reset = 1'b0;

  hex_keypad_emulator_if #(.FIFO_DEPTH(DEPTH)) kpIf ();

  hex_keypad_emulator #(
    .HOLD_CYCLES  (HOLD),
    .BOUNCE_CYCLES(BOUNCE),
    .GAP_CYCLES   (GAP),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (kpIf)
  );

  always #10 clock = ~clock;

  typedef struct {
    bit pressed;
    bit keyDone;
    bit busy;
    int count;
    bit ready;
    int key;
  } expect_t;

  expect_t    expQ [$];
  int         modelKeys [$];
  bit         modelActive = 1'b0;
  int         modelPos = 0;
  int         modelKey = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] colOpts [5];

  // Contact state at a given position within one key's full sequence.
  function automatic bit patternPressed(int pos);
    if (pos < BOUNCE) return (pos % 2) == 0;
    if (pos < BOUNCE + HOLD) return 1'b1;
    if (pos < 2 * BOUNCE + HOLD) return ((pos - BOUNCE - HOLD) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] rowOf(int key, bit pr, logic [3:0] colVal);
    logic [3:0] r;
    r = 4'b0000;
    if (pr && colVal[key % 4]) r[key / 4] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a key queue plus the position within the current key.
  always @(posedge clock or negedge reset) begin : modelStep
    int n;
    if (!reset) begin
      modelKeys.delete();
      modelActive = 1'b0;
      modelPos    = 0;
      modelKey    = 0;
      expQ.delete();
    end else begin
      n = modelKeys.size();
      if (kpIf.flush) begin
        modelKeys.delete();
        modelActive = 1'b0;
        modelPos    = 0;
      end else begin
        if (modelActive) begin
          if (modelPos == TOTAL - 1) modelActive = 1'b0;
          else modelPos++;
        end else if (n > 0) begin
          modelKey    = modelKeys.pop_front();
          modelActive = 1'b1;
          modelPos    = 0;
        end
        if (kpIf.key_valid && n < DEPTH) modelKeys.push_back(int'(kpIf.key_code));
      end
      expQ.push_back('{pressed: modelActive && patternPressed(modelPos),
                       keyDone: modelActive && (modelPos == TOTAL - 1),
                       busy:    modelActive,
                       count:   modelKeys.size(),
                       ready:   modelKeys.size() < DEPTH,
                       key:     modelKey});
    end
  end

  always @(negedge clock) begin : monitor
    expect_t e;
    if (reset && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("pressed",    32'(kpIf.pressed),    32'(e.pressed));
      checkOutput("key_done",   32'(kpIf.key_done),   32'(e.keyDone));
      checkOutput("busy",       32'(kpIf.busy),       32'(e.busy));
      checkOutput("fifo_count", 32'(kpIf.fifo_count), e.count);
      checkOutput("key_ready",  32'(kpIf.key_ready),  32'(e.ready));
      checkOutput("row",        32'(kpIf.row),        32'(rowOf(e.key, e.pressed, kpIf.col)));
    end
  end

  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic pushKey(input logic [3:0] code);
    nextCycle();
    kpIf.key_valid = 1'b1;
    kpIf.key_code  = code;
    nextCycle();
    kpIf.key_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) nextCycle();
  endtask

  task automatic waitPhase(input int lo, input int hi, input string what);
    for (int i = 0; i < 200; i++) begin
      nextCycle();
      if (modelActive && modelPos >= lo && modelPos <= hi) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_%s actual=timeout expected=reached", what);
  endtask

  task automatic applyStimulus(input int cycles, input int pushPct, input bit allowFlush);
    for (int i = 0; i < cycles; i++) begin
      nextCycle();
      kpIf.key_valid = ($urandom_range(0, 99) < pushPct);
      kpIf.key_code  = 4'($urandom_range(0, 15));
      kpIf.col       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : colOpts[$urandom_range(0, 4)];
      kpIf.flush     = allowFlush && ($urandom_range(0, 79) == 0);
    end
    nextCycle();
    kpIf.key_valid = 1'b0;
    kpIf.flush     = 1'b0;
  endtask

  initial begin
    colOpts[0] = 4'b0001;
    colOpts[1] = 4'b0010;
    colOpts[2] = 4'b0100;
    colOpts[3] = 4'b1000;
    colOpts[4] = 4'b1111;
    kpIf.key_valid = 1'b0;
    kpIf.key_code  = 4'h0;
    kpIf.flush     = 1'b0;
    kpIf.col       = 4'b1111;

    #25;
    checkOutput("reset_busy",       32'(kpIf.busy),       32'd0);
    checkOutput("reset_key_ready",  32'(kpIf.key_ready),  32'd1);
    checkOutput("reset_fifo_count", 32'(kpIf.fifo_count), 32'd0);
    checkOutput("reset_row",        32'(kpIf.row),        32'd0);
    checkOutput("reset_pressed",    32'(kpIf.pressed),    32'd0);
    checkOutput("reset_key_done",   32'(kpIf.key_done),   32'd0);
    reset = 1'b1;

    $display("[TB] single key 6 on column 2");
    kpIf.col = 4'b0100;
    pushKey(4'h6);
    idleCycles(TOTAL + 4);

    $display("[TB] column sweep while key 6 is held");
    kpIf.col = 4'b1111;
    pushKey(4'h6);
    waitPhase(BOUNCE, BOUNCE + HOLD - 2, "hold6");
    for (int i = 0; i < 5; i++) begin
      kpIf.col = colOpts[i];
      #1;
      checkOutput("sweep_row", 32'(kpIf.row), 32'(rowOf(6, 1'b1, colOpts[i])));
    end
    kpIf.col = 4'b1111;
    idleCycles(TOTAL + 4);

    $display("[TB] key F with bounce, all columns driven");
    pushKey(4'hF);
    idleCycles(TOTAL + 4);

    $display("[TB] five back-to-back pushes while a key is held");
    pushKey(4'h1);
    waitPhase(BOUNCE, BOUNCE + HOLD - 1, "hold1");
    kpIf.key_valid = 1'b1;
    kpIf.key_code  = 4'h2;
    nextCycle();
    kpIf.key_code  = 4'h3;
    nextCycle();
    kpIf.key_code  = 4'h9;
    nextCycle();
    kpIf.key_code  = 4'hA;
    nextCycle();
    kpIf.key_code  = 4'hC;
    nextCycle();
    kpIf.key_valid = 1'b0;
    idleCycles(5 * TOTAL + 10);

    $display("[TB] flush mid-hold with two keys queued");
    kpIf.key_valid = 1'b1;
    kpIf.key_code  = 4'h4;
    nextCycle();
    kpIf.key_code  = 4'h5;
    nextCycle();
    kpIf.key_code  = 4'h7;
    nextCycle();
    kpIf.key_valid = 1'b0;
    waitPhase(BOUNCE, BOUNCE + HOLD - 1, "hold4");
    kpIf.flush     = 1'b1;
    kpIf.key_valid = 1'b1;
    kpIf.key_code  = 4'hB;
    nextCycle();
    kpIf.flush     = 1'b0;
    kpIf.key_valid = 1'b0;
    checkOutput("flush_busy",       32'(kpIf.busy),       32'd0);
    checkOutput("flush_fifo_count", 32'(kpIf.fifo_count), 32'd0);
    checkOutput("flush_row",        32'(kpIf.row),        32'd0);
    checkOutput("flush_key_done",   32'(kpIf.key_done),   32'd0);
    idleCycles(TOTAL + 4);

    $display("[TB] asynchronous reset during press bounce");
    pushKey(4'hD);
    waitPhase(2, 2, "bounce_in");
    checkOutput("pre_reset_row", 32'(kpIf.row), 32'(rowOf(13, 1'b1, kpIf.col)));
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_row",        32'(kpIf.row),        32'd0);
    checkOutput("async_pressed",    32'(kpIf.pressed),    32'd0);
    checkOutput("async_busy",       32'(kpIf.busy),       32'd0);
    checkOutput("async_fifo_count", 32'(kpIf.fifo_count), 32'd0);
    #2;
    reset = 1'b1;
    idleCycles(10);

    $display("[TB] randomized traffic");
    applyStimulus(400, 40, 1'b1);
    applyStimulus(300, 10, 1'b0);
    applyStimulus(200, 70, 1'b1);
    idleCycles(DEPTH * TOTAL + 2 * TOTAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
